select_n_antitoken: RTL
=======================

// Module: select_n_antitoken
// PURPOSE
//  N-way dataflow select with a lazy-discard (antitoken) policy. Emits ins[sel] once
//  the condition token and the selected data token are present. It does not wait
//  for the unselected inputs. Their late tokens are discarded by per-input
//  saturating antitoken counters, so up to MAX_ANTI discards can be outstanding per
//  input. Used by the arith library in place of the 2-input selector on N-way
//  speculative merges.
// PARAMETERS
//  DATA_WIDTH  32  width of each data input and of result
//  NUM_INPUTS   4  number of data inputs, >=2
//  SEL_WIDTH    2  width of sel, >=$clog2(NUM_INPUTS)
//  MAX_ANTI     3  max pending antitokens per input, >=1; counter width $clog2(MAX_ANTI+1)
// PORTS
//  clk         in   1                      clock, rising edge
//  reset       in   1                      asynchronous, active-high
//  sel         in   SEL_WIDTH              index of the input to forward
//  sel_valid   in   1                      condition token present
//  sel_ready   out  1                      condition token consumed
//  ins         in   NUM_INPUTS*DATA_WIDTH  packed data; input i = ins[i*DATA_WIDTH +: DATA_WIDTH]
//  ins_valid   in   NUM_INPUTS             per-input valid
//  ins_ready   out  NUM_INPUTS             per-input ready (consume or discard)
//  result      out  DATA_WIDTH             ins[sel]
//  result_valid out 1
//  result_ready in  1
// BEHAVIOUR
//  Clock and reset
//  - clk: single clock, rising edge. reset: asynchronous, active-high.
//  - Reset clears all cnt[i] to 0. The block has no other state.
//  - All outputs are combinational from state and inputs. While reset is high:
//    result_valid=0, sel_ready=0, ins_ready=0.
//  - Reset asserted mid-operation drops every pending antitoken.
//  Token signals
//  - fresh[i] = ins_valid[i] & (cnt[i]==0). A token arriving while cnt[i]>0 is stale.
//  - kill[i] = ins_valid[i] & (cnt[i]>0).
//  - block = OR over i!=sel of (cnt[i]==MAX_ANTI & !ins_valid[i]).
//  - legal = sel < NUM_INPUTS.
//  Handshake and datapath
//  - result_valid = sel_valid & legal & fresh[sel] & !block.
//  - fire = result_valid & result_ready.
//  - sel_ready = fire.
//  - ins_ready[i] = kill[i] | (fire & fresh[i]). A fresh unselected token present at
//    fire is consumed and dropped in the same cycle.
//  - result = ins[sel] when legal, else 0. Zero latency, no data register.
//    Throughput is 1 token per cycle.
//  Counter update per input i, at the clock edge:
//  - inc[i] = fire & (i!=sel) & !fresh[i].
//  - dec[i] = kill[i].
//  - cnt[i] += inc[i] - dec[i].
//  - inc and dec in the same cycle leave cnt unchanged. This is how a token is
//    killed at MAX_ANTI without stalling.
//  Boundary conditions
//  - cnt never exceeds MAX_ANTI and never goes below 0; block guarantees this.
//    The bench asserts it.
//  - The selected input with cnt[sel]>0: its stale tokens are killed first.
//    result_valid stays 0 until a fresh token arrives.
//  - Out-of-range sel: the condition is never consumed and result_valid=0.
//    This is a simulation assertion failure, not a recovered case.
//  - result_ready low: no state change except kills, which proceed independently.
// STRUCTURE
//  - Sub-module antitoken_counter, instantiated NUM_INPUTS times.
//    Params: MAX_ANTI.
//    Ports: clk, reset, inc, dec, count_zero, count_full.
//    Async reset, saturating up/down counter.
//  - No shared package. Counter width is a localparam.
//  - The top level holds the sel decode, block/fresh logic and the data mux.
// TESTING
//  1. Reset, sel=1 valid, ins_valid=4'b0010, ins[1]=0xA5, ready=1
//     -> result=0xA5, valid=1 same cycle; next cycle cnt={1,0,1,1}.
//  2. After 1, assert ins_valid=4'b1101 for one cycle
//     -> ins_ready=4'b1101, no result; cnt returns to all 0.
//  3. MAX_ANTI=3: four fires with sel=0, inputs 1..3 idle
//     -> 4th fire blocked (result_valid=0) until any input 1..3 valid arrives.
//  4. cnt[2]=3, ins_valid[2]=1 during fire with sel=0
//     -> not blocked, ins_ready[2]=1, cnt[2] stays 3.
//  5. cnt[1]=2, sel=1, ins_valid[1]=1 for 3 cycles
//     -> first 2 tokens killed; result_valid only on the 3rd.
//  6. Assert reset with cnt={2,1,0,3}
//     -> all cnt=0 immediately, all outputs 0; normal select on the next cycle.

Source files
------------

// File: rtl/antitoken_counter.sv
// Saturating up/down counter holding the number of late tokens still owed a
// discard on one select input.
module antitoken_counter #(
  parameter int MAX_ANTI = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic count_zero,
  output logic count_full
);

  localparam int CW = $clog2(MAX_ANTI + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_ANTI);

  logic [CW-1:0] count;

  // Simultaneous inc and dec cancel, which lets a full counter kill a token
  // in the same cycle it owes a new one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !dec && count != MAX_CNT) begin
      count <= count + CW'(1);
    end else if (dec && !inc && count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign count_zero = (count == '0);
  assign count_full = (count == MAX_CNT);

endmodule

// File: rtl/select_n_antitoken.sv
// N-way dataflow select: forwards ins[sel] as soon as the condition and the
// selected token are present; late tokens on other inputs are discarded later.
module select_n_antitoken #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_INPUTS = 4,
  parameter int SEL_WIDTH  = 2,
  parameter int MAX_ANTI   = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [SEL_WIDTH-1:0]             sel,
  input  logic                             sel_valid,
  output logic                             sel_ready,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] ins,
  input  logic [NUM_INPUTS-1:0]            ins_valid,
  output logic [NUM_INPUTS-1:0]            ins_ready,
  output logic [DATA_WIDTH-1:0]            result,
  output logic                             result_valid,
  input  logic                             result_ready
);

  localparam logic [31:0] NUM_U = 32'(NUM_INPUTS);

  logic [31:0]            sel_ext;
  logic [NUM_INPUTS-1:0]  cnt_zero;
  logic [NUM_INPUTS-1:0]  cnt_full;
  logic [NUM_INPUTS-1:0]  fresh;
  logic [NUM_INPUTS-1:0]  kill;
  logic [NUM_INPUTS-1:0]  inc;
  logic                   legal;
  logic                   block;
  logic                   sel_fresh;
  logic                   valid_int;
  logic                   fire;
  logic [DATA_WIDTH-1:0]  mux;

  assign sel_ext = 32'(sel);
  assign legal   = (sel_ext < NUM_U);
  assign fresh   = ins_valid & cnt_zero;
  assign kill    = ins_valid & ~cnt_zero;

  // An unselected input already owing MAX_ANTI discards cannot absorb another,
  // so the fire waits unless that input's token is here to be killed now.
  always_comb begin
    block     = 1'b0;
    sel_fresh = 1'b0;
    mux       = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      if (sel_ext == i) begin
        sel_fresh = fresh[i];
        mux       = ins[i*DATA_WIDTH +: DATA_WIDTH];
      end else if (cnt_full[i] && !ins_valid[i]) begin
        block = 1'b1;
      end
    end
  end

  assign valid_int = sel_valid & legal & sel_fresh & ~block;
  assign fire      = valid_int & result_ready;

  always_comb begin
    inc = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      inc[i] = fire & (sel_ext != i) & ~fresh[i];
    end
  end

  assign result_valid = valid_int & ~reset;
  assign sel_ready    = fire & ~reset;
  assign ins_ready    = reset ? '0 : (kill | ({NUM_INPUTS{fire}} & fresh));
  assign result       = reset ? '0 : mux;

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_cnt
    antitoken_counter #(
      .MAX_ANTI(MAX_ANTI)
    ) u_cnt (
      .clk       (clk),
      .reset     (reset),
      .inc       (inc[g]),
      .dec       (kill[g]),
      .count_zero(cnt_zero[g]),
      .count_full(cnt_full[g])
    );
  end

  a_sel_legal: assert property (@(posedge clk) disable iff (reset) sel_valid |-> legal);

endmodule
